elem_sub_arbiter: RTL

- Shares one modular-subtract pipe (ElemSub: out = (op1 - op2) mod p, fixed latency, no backpressure) among NUM_REQ vector requesters.
- Arbitration is per vector burst (first beat to last beat), round-robin between bursts.
- Latches the burst's modulus and tags each in-flight beat so results route back to the owning requester.
- Sits between the vector-op issue stage and the shared subtract unit in the FHE ALU.

---
 rtl/elem_sub_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/elem_sub_arbiter.sv
// Burst-level round-robin arbiter in front of the shared ElemSub modular-subtract pipe.
// Tags every issued beat with its owner so results route back without backpressure.
module elem_sub_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 64,
  parameter int SUB_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*W-1:0] req_op1,
  input  logic [NUM_REQ*W-1:0] req_op2,
  input  logic [NUM_REQ*W-1:0] req_p,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 sub_in_valid,
  output logic                 sub_in_last,
  output logic [W-1:0]         sub_op1,
  output logic [W-1:0]         sub_op2,
  output logic [W-1:0]         sub_p,
  input  logic [W-1:0]         sub_out,
  input  logic                 sub_out_valid,
  input  logic                 sub_out_last,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [NUM_REQ-1:0]   rsp_last,
  output logic [W-1:0]         rsp_data,
  output logic                 burst_done,
  output logic [1:0]           burst_id,
  output logic [CNT_W-1:0]     burst_len,
  output logic                 busy
);

  // state   | meaning
  // S_IDLE  | no owner; pick next requester round-robin
  // S_GRANT | owner chosen; first accepted beat latches the modulus
  // S_BURST | owner streams remaining beats until its last beat
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST} state_t;

  typedef struct packed {
    logic             vld;
    logic             last;
    logic [1:0]       id;
    logic [CNT_W-1:0] len;
  } tag_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_gnt, r_rr_ptr, w_pick;
  logic             w_pick_vld;
  logic [W-1:0]     r_p;
  logic [CNT_W-1:0] r_cnt;
  tag_t             r_in_tag;
  tag_t             r_tag [SUB_LAT];
  tag_t             w_out_tag;
  logic             w_acc, w_acc_last, w_out_vld, w_tag_any;
  logic [W-1:0]     w_op1, w_op2, w_p;

  // Scan from rr_ptr+1; iterating k downwards lets the nearest valid requester win.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (i == (int'(r_rr_ptr) + k) % NUM_REQ)) begin
          w_pick_vld = 1'b1;
          w_pick     = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_acc      = 1'b0;
    w_acc_last = 1'b0;
    w_op1      = '0;
    w_op2      = '0;
    w_p        = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt == 2'(i)) begin
        w_op1 = req_op1[i*W +: W];
        w_op2 = req_op2[i*W +: W];
        w_p   = req_p[i*W +: W];
        if (r_state != S_IDLE) begin
          req_ready[i] = 1'b1;
          w_acc        = req_valid[i];
          w_acc_last   = req_valid[i] & req_last[i];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_GRANT;
      S_GRANT: if (w_acc) w_state_nxt = w_acc_last ? S_IDLE : S_BURST;
      S_BURST: if (w_acc_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_rr_ptr     <= 2'(NUM_REQ - 1);
      r_p          <= '0;
      r_cnt        <= '0;
      sub_in_valid <= 1'b0;
      sub_in_last  <= 1'b0;
      sub_op1      <= '0;
      sub_op2      <= '0;
      sub_p        <= '0;
      r_in_tag     <= '0;
      for (int k = 0; k < SUB_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_pick_vld) begin
        r_gnt <= w_pick;
        r_cnt <= '0;
      end
      if (w_acc) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        sub_op1 <= w_op1;
        sub_op2 <= w_op2;
        // First beat bypasses r_p so the modulus is valid on the same issue cycle.
        sub_p   <= (r_state == S_GRANT) ? w_p : r_p;
        if (r_state == S_GRANT) r_p <= w_p;
        if (w_acc_last) r_rr_ptr <= r_gnt;
      end
      sub_in_valid  <= w_acc;
      sub_in_last   <= w_acc_last;
      r_in_tag.vld  <= w_acc;
      r_in_tag.last <= w_acc_last;
      r_in_tag.id   <= r_gnt;
      r_in_tag.len  <= w_acc_last ? r_cnt + CNT_W'(1) : '0;
      r_tag[0]      <= r_in_tag;
      for (int k = 1; k < SUB_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_out_tag = r_tag[SUB_LAT-1];
  assign w_out_vld = sub_out_valid & w_out_tag.vld;

  always_comb begin
    rsp_valid = '0;
    rsp_last  = '0;
    w_tag_any = r_in_tag.vld;
    for (int k = 0; k < SUB_LAT; k++) w_tag_any = w_tag_any | r_tag[k].vld;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_out_vld && w_out_tag.id == 2'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_last[i]  = sub_out_last;
      end
    end
  end

  assign rsp_data   = sub_out;
  assign burst_done = w_out_vld & w_out_tag.last;
  assign burst_id   = burst_done ? w_out_tag.id : 2'b00;
  assign burst_len  = burst_done ? w_out_tag.len : '0;
  assign busy       = (r_state != S_IDLE) | w_tag_any;

endmodule
